// File: rtl/rf68000_addsub_seq.sv
// Slice-serial 68000 ADD/SUB/ADDX/SUBX/NEG/NEGX/CMP unit, processing SLICE bits per clock.
// The sized msb is split off in the top slice to derive V as carry-into-msb XOR carry-out.
module rf68000_addsub_seq #(
    parameter int unsigned WID   = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             ready_o,
    input  logic             abort_i,
    input  logic [2:0]       op_i,
    input  logic [1:0]       size_i,
    input  logic [WID-1:0]   a_i,
    input  logic [WID-1:0]   b_i,
    input  logic             x_i,
    input  logic             z_i,
    output logic [WID-1:0]   res_o,
    output logic             x_o,
    output logic             n_o,
    output logic             z_o,
    output logic             v_o,
    output logic             c_o,
    output logic             valid_o,
    input  logic             res_ready_i
);

    localparam int unsigned CNT_W = 6;
    localparam logic [SLICE-1:0] LO_MSK = SLICE'((2 ** (SLICE - 1)) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [1:0]         sz_q;
    logic [WID-1:0]     a_q;
    logic [WID-1:0]     sa_q;
    logic [WID-1:0]     sb_q;
    logic [WID-1:0]     acc_q;
    logic               x_q;
    logic               z_q;
    logic               cy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   nsl_q;

    function automatic logic op_uses_x(input logic [2:0] op);
        return (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
    endfunction

    logic               is_sub, is_neg, is_x, is_cmp, last;
    logic [SLICE-1:0]   da, db, sl, lo;
    logic [SLICE:0]     full;
    logic               cout, cmsb;
    logic [WID-1:0]     acc_n, rs, msk;
    logic [1:0]         sz_in;

    // Per-slice arithmetic; lo carries only the bits below the slice msb
    always_comb begin
        is_sub = (op_q == 3'd1) || (op_q == 3'd3) || (op_q == 3'd6) || is_neg;
        is_neg = (op_q == 3'd4) || (op_q == 3'd5);
        is_x   = op_uses_x(op_q);
        is_cmp = (op_q == 3'd6);
        da     = is_neg ? '0 : sa_q[SLICE-1:0];
        db     = sb_q[SLICE-1:0];
        if (is_sub) begin
            full = {1'b0, da} - {1'b0, db} - (SLICE+1)'(cy_q);
            lo   = (da & LO_MSK) - (db & LO_MSK) - SLICE'(cy_q);
        end else begin
            full = {1'b0, da} + {1'b0, db} + (SLICE+1)'(cy_q);
            lo   = (da & LO_MSK) + (db & LO_MSK) + SLICE'(cy_q);
        end
        sl    = full[SLICE-1:0];
        cout  = full[SLICE];
        cmsb  = lo[SLICE-1];
        acc_n = {sl, acc_q[WID-1:SLICE]};
        last  = (cnt_q == nsl_q - CNT_W'(1));
        sz_in = (size_i == 2'd3) ? 2'd2 : size_i;
        case (sz_q)
            2'd0:    begin rs = acc_n >> (WID - 8);  msk = WID'(8'hFF);    end
            2'd1:    begin rs = acc_n >> (WID - 16); msk = WID'(16'hFFFF); end
            default: begin rs = acc_n;               msk = '1;             end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            res_o   <= '0;
            x_o     <= 1'b0;
            n_o     <= 1'b0;
            z_o     <= 1'b0;
            v_o     <= 1'b0;
            c_o     <= 1'b0;
            cy_q    <= 1'b0;
            op_q    <= '0;
            sz_q    <= '0;
            a_q     <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            x_q     <= 1'b0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
            nsl_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_q    <= (op_i == 3'd7) ? 3'd0 : op_i;
                        sz_q    <= sz_in;
                        a_q     <= a_i;
                        sa_q    <= a_i;
                        sb_q    <= b_i;
                        x_q     <= x_i;
                        z_q     <= z_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        nsl_q   <= CNT_W'((32'd8 << sz_in) / SLICE);
                        cy_q    <= x_i & op_uses_x(op_i);
                        ready_o <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        ready_o <= 1'b1;
                        valid_o <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        sa_q  <= sa_q >> SLICE;
                        sb_q  <= sb_q >> SLICE;
                        acc_q <= acc_n;
                        cy_q  <= cout;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last) begin
                            res_o   <= is_cmp ? a_q : ((a_q & ~msk) | rs);
                            c_o     <= cout;
                            v_o     <= cout ^ cmsb;
                            n_o     <= sl[SLICE-1];
                            z_o     <= (rs == '0) & (is_x ? z_q : 1'b1);
                            x_o     <= is_cmp ? x_q : cout;
                            valid_o <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (abort_i || res_ready_i) begin
                        ready_o <= 1'b1;
                        valid_o <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf68000_addsub_seq.sv
// Randomized bench for rf68000_addsub_seq: SLICE=8 and SLICE=1 instances against a
// plain-arithmetic reference model, plus backpressure, abort and reset scenarios.
module tb_rf68000_addsub_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start8, start1, abort, rr;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] a, b;
    logic        x, z;

    logic        rdy8, x8, n8, z8, v8, c8, val8;
    logic        rdy1, x1, n1, z1, v1, c1, val1;
    logic [31:0] res8, res1;

    rf68000_addsub_seq #(.WID(32), .SLICE(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .ready_o(rdy8), .abort_i(abort),
        .op_i(op), .size_i(size), .a_i(a), .b_i(b), .x_i(x), .z_i(z),
        .res_o(res8), .x_o(x8), .n_o(n8), .z_o(z8), .v_o(v8), .c_o(c8),
        .valid_o(val8), .res_ready_i(rr));

    rf68000_addsub_seq #(.WID(32), .SLICE(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .ready_o(rdy1), .abort_i(abort),
        .op_i(op), .size_i(size), .a_i(a), .b_i(b), .x_i(x), .z_i(z),
        .res_o(res1), .x_o(x1), .n_o(n1), .z_o(z1), .v_o(v1), .c_o(c1),
        .valid_o(val1), .res_ready_i(rr));

    typedef struct packed {
        logic [31:0] res;
        logic        x, n, z, v, c;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sized integer arithmetic, carry/overflow from true unsigned/signed ranges
    function automatic exp_t model(input logic [2:0] o, input logic [1:0] s,
                                   input logic [31:0] aa, input logic [31:0] bb,
                                   input logic xx, input logic zz);
        exp_t   e;
        int     nb;
        longint mask, half, ua, ub, sa, sb, ut, st, r, cin;
        logic   sub, xop;
        logic [2:0] opn;
        opn  = (o == 3'd7) ? 3'd0 : o;
        nb   = (s == 2'd0) ? 8 : (s == 2'd1) ? 16 : 32;
        mask = (longint'(1) << nb) - 1;
        half = longint'(1) << (nb - 1);
        ua   = longint'({32'd0, aa}) & mask;
        ub   = longint'({32'd0, bb}) & mask;
        if (opn == 3'd4 || opn == 3'd5) ua = 0;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        xop  = (opn == 3'd2) || (opn == 3'd3) || (opn == 3'd5);
        cin  = (xop && xx) ? 1 : 0;
        sub  = (opn != 3'd0) && (opn != 3'd2);
        if (sub) begin
            ut = ua - ub - cin;
            st = sa - sb - cin;
        end else begin
            ut = ua + ub + cin;
            st = sa + sb + cin;
        end
        r     = ut & mask;
        e.c   = sub ? (ut < 0) : (ut > mask);
        e.v   = (st < -half) || (st >= half);
        e.n   = ((r >> (nb - 1)) & 1) != 0;
        e.z   = (r == 0) && (!xop || zz);
        e.x   = (opn == 3'd6) ? xx : e.c;
        e.res = (opn == 3'd6) ? aa : ((aa & ~mask[31:0]) | r[31:0]);
        return e;
    endfunction

    task automatic check_outs(input string p, input exp_t e, input logic [31:0] r,
                              input logic xx, input logic nn, input logic zz,
                              input logic vv, input logic cc);
        chk({p, "_res"}, r, e.res);
        chk({p, "_x"}, 32'(xx), 32'(e.x));
        chk({p, "_n"}, 32'(nn), 32'(e.n));
        chk({p, "_z"}, 32'(zz), 32'(e.z));
        chk({p, "_v"}, 32'(vv), 32'(e.v));
        chk({p, "_c"}, 32'(cc), 32'(e.c));
    endtask

    // Wait (bounded) for the SLICE=8 instance's valid and check latency and outputs
    task automatic wait8(input string p, input int lat, input exp_t e);
        logic got;
        got = 1'b0;
        for (int t = 1; t <= 12 && !got; t++) begin
            tick();
            if (val8) begin
                got = 1'b1;
                chk({p, "_lat"}, 32'(t), 32'(lat));
                check_outs(p, e, res8, x8, n8, z8, v8, c8);
            end
        end
        if (!got) chk({p, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Run one operation on both instances with res_ready held high
    task automatic run_op(input logic [2:0] o, input logic [1:0] s, input logic [31:0] aa,
                          input logic [31:0] bb, input logic xx, input logic zz);
        exp_t e;
        int   nbits;
        logic got8, got1;
        e     = model(o, s, aa, bb, xx, zz);
        nbits = (s == 2'd0) ? 8 : (s == 2'd1) ? 16 : 32;
        op = o; size = s; a = aa; b = bb; x = xx; z = zz;
        start8 = 1'b1; start1 = 1'b1; rr = 1'b1;
        chk("ready8_idle", 32'(rdy8), 32'd1);
        chk("ready1_idle", 32'(rdy1), 32'd1);
        tick();
        start8 = 1'b0; start1 = 1'b0;
        op = 3'($urandom); size = 2'($urandom); a = $urandom; b = $urandom;
        x = 1'($urandom); z = 1'($urandom);
        chk("ready8_busy", 32'(rdy8), 32'd0);
        got8 = 1'b0; got1 = 1'b0;
        for (int t = 1; t <= 40 && !(got8 && got1); t++) begin
            tick();
            if (!got8 && val8) begin
                got8 = 1'b1;
                chk("lat8", 32'(t), 32'(nbits / 8));
                check_outs("d8", e, res8, x8, n8, z8, v8, c8);
            end
            if (!got1 && val1) begin
                got1 = 1'b1;
                chk("lat1", 32'(t), 32'(nbits));
                check_outs("d1", e, res1, x1, n1, z1, v1, c1);
            end
        end
        if (!got8) chk("timeout8", 32'd0, 32'd1);
        if (!got1) chk("timeout1", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        exp_t        e;
        logic [31:0] prev;
        int          seen;
        rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0; abort = 1'b0; rr = 1'b1;
        op = '0; size = '0; a = '0; b = '0; x = 1'b0; z = 1'b0;
        tick(); tick();
        chk("rst_ready", 32'(rdy8), 32'd1);
        chk("rst_valid", 32'(val8), 32'd0);
        chk("rst_res", res8, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(3'd0, 2'd0, 32'h1234567F, 32'h00000001, 1'b0, 1'b0);
        run_op(3'd1, 2'd2, 32'h00000000, 32'h00000001, 1'b0, 1'b0);
        run_op(3'd2, 2'd1, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b1);
        run_op(3'd2, 2'd1, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0);
        run_op(3'd6, 2'd2, 32'h80000000, 32'h00000001, 1'b1, 1'b0);
        run_op(3'd4, 2'd0, 32'h00000000, 32'h00000080, 1'b0, 1'b0);
        run_op(3'd7, 2'd3, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1);
        for (int i = 0; i < 120; i++)
            run_op(3'($urandom), 2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));

        // Backpressure in DONE while start is pulsed
        e  = model(3'd1, 2'd2, 32'h0, 32'h1, 1'b0, 1'b0);
        rr = 1'b0; op = 3'd1; size = 2'd2; a = 32'h0; b = 32'h1; x = 1'b0; z = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait8("bp", 4, e);
        for (int i = 0; i < 3; i++) begin
            start8 = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
            tick();
            chk("bp_valid", 32'(val8), 32'd1);
            chk("bp_ready", 32'(rdy8), 32'd0);
            chk("bp_res", res8, e.res);
            chk("bp_c", 32'(c8), 32'(e.c));
        end
        start8 = 1'b0; rr = 1'b1;
        tick();
        chk("bp_rel_valid", 32'(val8), 32'd0);
        chk("bp_rel_ready", 32'(rdy8), 32'd1);
        e = model(3'd0, 2'd0, 32'hA5A5A5F0, 32'h00000020, 1'b0, 1'b0);
        op = 3'd0; size = 2'd0; a = 32'hA5A5A5F0; b = 32'h00000020; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("bp_next_accept", 32'(rdy8), 32'd0);
        wait8("bp_next", 1, e);
        tick();

        // Abort during the third RUN slice of SUB.L
        prev = res8;
        op = 3'd1; size = 2'd2; a = 32'h12345678; b = 32'h11111111; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ready", 32'(rdy8), 32'd1);
        chk("abort_valid", 32'(val8), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (val8) seen++;
        end
        chk("abort_noval", 32'(seen), 32'd0);
        chk("abort_res_kept", res8, prev);

        // Synchronous reset mid-RUN
        op = 3'd1; size = 2'd2; a = 32'h0; b = 32'h1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_ready", 32'(rdy8), 32'd1);
        chk("mrst_valid", 32'(val8), 32'd0);
        chk("mrst_res8", res8, 32'd0);
        chk("mrst_res1", res1, 32'd0);
        chk("mrst_flags", {27'd0, x8, n8, z8, v8, c8}, 32'd0);
        tick();
        run_op(3'd3, 2'd0, 32'h00000000, 32'h00000000, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
